// File: rtl/vtage_update_unit_if.sv
// Commit-record input, useful-bit read and bank write bundle of the VTAGE update unit.
// The slave modport is the update unit; master is the commit logic / bank side.
interface vtage_update_unit_if #(
  parameter int P_NUM_BANKS = 6,
  parameter int P_VAL_W     = 64,
  parameter int P_IDX_W     = 10,
  parameter int P_TAG_W     = 12,
  parameter int P_CONF_W    = 3
);
  localparam int BID_W = $clog2(P_NUM_BANKS + 1);

  logic                               cmt_valid;
  logic                               cmt_ready;
  logic [P_VAL_W-1:0]                 cmt_value;
  logic [P_VAL_W-1:0]                 cmt_alt_value;
  logic [BID_W-1:0]                   cmt_prov;
  logic [P_CONF_W-1:0]                cmt_prov_conf;
  logic                               cmt_prov_useful;
  logic [P_VAL_W-1:0]                 cmt_pred_value;
  logic [(P_NUM_BANKS+1)*P_IDX_W-1:0] cmt_idx;
  logic [P_NUM_BANKS*P_TAG_W-1:0]     cmt_tag;

  logic                               u_rd_en;
  logic [P_NUM_BANKS*P_IDX_W-1:0]     u_rd_idx;
  logic [P_NUM_BANKS-1:0]             u_rd_bits;

  logic                               wr_en;
  logic [BID_W-1:0]                   wr_bank;
  logic [P_IDX_W-1:0]                 wr_idx;
  logic [P_TAG_W-1:0]                 wr_tag;
  logic [P_VAL_W-1:0]                 wr_value;
  logic [P_CONF_W-1:0]                wr_conf;
  logic                               wr_useful;
  logic                               wr_u_only;
  logic                               u_clear;
  logic                               busy;

  modport slave (
    input  cmt_valid, cmt_value, cmt_alt_value, cmt_prov, cmt_prov_conf,
           cmt_prov_useful, cmt_pred_value, cmt_idx, cmt_tag, u_rd_bits,
    output cmt_ready, u_rd_en, u_rd_idx, wr_en, wr_bank, wr_idx, wr_tag,
           wr_value, wr_conf, wr_useful, wr_u_only, u_clear, busy
  );

  modport master (
    output cmt_valid, cmt_value, cmt_alt_value, cmt_prov, cmt_prov_conf,
           cmt_prov_useful, cmt_pred_value, cmt_idx, cmt_tag, u_rd_bits,
    input  cmt_ready, u_rd_en, u_rd_idx, wr_en, wr_bank, wr_idx, wr_tag,
           wr_value, wr_conf, wr_useful, wr_u_only, u_clear, busy
  );
endinterface

// File: rtl/vtage_update_unit.sv
// Commit-side VTAGE trainer: buffers commit records and serialises provider update,
// mispredict allocation and useful-bit clearing into single-port bank writes.
module vtage_update_unit #(
  parameter int P_NUM_BANKS  = 6,
  parameter int P_VAL_W      = 64,
  parameter int P_IDX_W      = 10,
  parameter int P_TAG_W      = 12,
  parameter int P_CONF_W     = 3,
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_URST_W     = 8
) (
  input logic                clk,
  input logic                rst_n,
  vtage_update_unit_if.slave bus
);
  localparam int BID_W = $clog2(P_NUM_BANKS + 1);
  localparam int PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int SLOTS = 2 ** BID_W;
  localparam logic [BID_W-1:0]    LAST_BANK = BID_W'(P_NUM_BANKS);
  localparam logic [P_CONF_W-1:0] CONF_MAX  = '1;
  localparam logic [PTR_W:0]      FIFO_FULL = (PTR_W+1)'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_PROV, S_URD, S_CHK, S_ALLOC, S_CLR, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BID_W-1:0]      bank_q, bank_d;
  logic [P_URST_W-1:0]   upd_cnt_q, upd_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  full, empty, push, pop;

  logic [P_VAL_W-1:0]                 mem_value  [P_FIFO_DEPTH];
  logic [P_VAL_W-1:0]                 mem_alt    [P_FIFO_DEPTH];
  logic [P_VAL_W-1:0]                 mem_pred   [P_FIFO_DEPTH];
  logic [BID_W-1:0]                   mem_prov   [P_FIFO_DEPTH];
  logic [P_CONF_W-1:0]                mem_conf   [P_FIFO_DEPTH];
  logic                               mem_useful [P_FIFO_DEPTH];
  logic [(P_NUM_BANKS+1)*P_IDX_W-1:0] mem_idx    [P_FIFO_DEPTH];
  logic [P_NUM_BANKS*P_TAG_W-1:0]     mem_tag    [P_FIFO_DEPTH];

  logic [P_VAL_W-1:0]                 h_value, h_alt, h_pred;
  logic [BID_W-1:0]                   h_prov;
  logic [P_CONF_W-1:0]                h_conf;
  logic                               h_useful, h_correct;
  logic [(P_NUM_BANKS+1)*P_IDX_W-1:0] h_idx;
  logic [P_NUM_BANKS*P_TAG_W-1:0]     h_tag;
  logic [P_IDX_W-1:0]                 idx_slot [SLOTS];
  logic [P_TAG_W-1:0]                 tag_slot [SLOTS];

  logic                  free_found;
  logic [BID_W-1:0]      free_bank;
  logic                  wr_en, wr_useful, wr_u_only, u_rd_en, u_clear;
  logic [BID_W-1:0]      wr_bank;
  logic [P_IDX_W-1:0]    wr_idx;
  logic [P_TAG_W-1:0]    wr_tag;
  logic [P_VAL_W-1:0]    wr_value;
  logic [P_CONF_W-1:0]   wr_conf;
  logic [P_NUM_BANKS*P_IDX_W-1:0] u_rd_idx;

  assign full  = (count_q == FIFO_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.cmt_valid & ~full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Record storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_value[wr_ptr_q]  <= bus.cmt_value;
      mem_alt[wr_ptr_q]    <= bus.cmt_alt_value;
      mem_pred[wr_ptr_q]   <= bus.cmt_pred_value;
      mem_prov[wr_ptr_q]   <= bus.cmt_prov;
      mem_conf[wr_ptr_q]   <= bus.cmt_prov_conf;
      mem_useful[wr_ptr_q] <= bus.cmt_prov_useful;
      mem_idx[wr_ptr_q]    <= bus.cmt_idx;
      mem_tag[wr_ptr_q]    <= bus.cmt_tag;
    end
  end

  assign h_value   = mem_value[rd_ptr_q];
  assign h_alt     = mem_alt[rd_ptr_q];
  assign h_pred    = mem_pred[rd_ptr_q];
  assign h_prov    = mem_prov[rd_ptr_q];
  assign h_conf    = mem_conf[rd_ptr_q];
  assign h_useful  = mem_useful[rd_ptr_q];
  assign h_idx     = mem_idx[rd_ptr_q];
  assign h_tag     = mem_tag[rd_ptr_q];
  assign h_correct = (h_pred == h_value);

  // Slot tables padded to a power of two so any bank id indexes safely; base has no tag.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi <= P_NUM_BANKS) begin : g_idx
      assign idx_slot[gi] = h_idx[gi*P_IDX_W +: P_IDX_W];
    end else begin : g_idx_pad
      assign idx_slot[gi] = '0;
    end
    if (gi >= 1 && gi <= P_NUM_BANKS) begin : g_tag
      assign tag_slot[gi] = h_tag[(gi-1)*P_TAG_W +: P_TAG_W];
    end else begin : g_tag_pad
      assign tag_slot[gi] = '0;
    end
  end

  // Descending scan so the lowest free bank above the provider wins.
  always_comb begin
    free_found = 1'b0;
    free_bank  = '0;
    for (int k = P_NUM_BANKS; k >= 1; k--) begin
      if (k > int'(h_prov) && !bus.u_rd_bits[k-1]) begin
        free_found = 1'b1;
        free_bank  = BID_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bank_q    <= '0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    upd_cnt_d = upd_cnt_q;
    pop       = 1'b0;
    wr_en     = 1'b0;
    wr_bank   = '0;
    wr_idx    = '0;
    wr_tag    = '0;
    wr_value  = '0;
    wr_conf   = '0;
    wr_useful = 1'b0;
    wr_u_only = 1'b0;
    u_rd_en   = 1'b0;
    u_rd_idx  = '0;
    u_clear   = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_PROV;
      S_PROV: begin
        wr_en   = 1'b1;
        wr_bank = h_prov;
        wr_idx  = idx_slot[h_prov];
        wr_tag  = tag_slot[h_prov];
        if (h_correct) begin
          wr_conf   = (h_conf == CONF_MAX) ? CONF_MAX : h_conf + 1'b1;
          wr_value  = h_pred;
          wr_useful = h_useful | (h_alt != h_value);
          state_d   = S_DONE;
        end else begin
          wr_conf   = '0;
          wr_value  = h_value;
          wr_useful = h_useful;
          state_d   = (h_prov == LAST_BANK) ? S_DONE : S_URD;
        end
      end
      S_URD: begin
        u_rd_en  = 1'b1;
        u_rd_idx = h_idx[(P_NUM_BANKS+1)*P_IDX_W-1 : P_IDX_W];
        state_d  = S_CHK;
      end
      S_CHK: begin
        if (free_found) begin
          bank_d  = free_bank;
          state_d = S_ALLOC;
        end else begin
          bank_d  = h_prov + 1'b1;
          state_d = S_CLR;
        end
      end
      S_ALLOC: begin
        wr_en    = 1'b1;
        wr_bank  = bank_q;
        wr_idx   = idx_slot[bank_q];
        wr_tag   = tag_slot[bank_q];
        wr_value = h_value;
        state_d  = S_DONE;
      end
      S_CLR: begin
        wr_en     = 1'b1;
        wr_u_only = 1'b1;
        wr_bank   = bank_q;
        wr_idx    = idx_slot[bank_q];
        bank_d    = bank_q + 1'b1;
        if (bank_q == LAST_BANK) state_d = S_DONE;
      end
      S_DONE: begin
        pop       = 1'b1;
        upd_cnt_d = upd_cnt_q + 1'b1;
        u_clear   = &upd_cnt_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmt_ready = ~full;
  assign bus.busy      = ~empty | (state_q != S_IDLE);
  assign bus.wr_en     = wr_en;
  assign bus.wr_bank   = wr_bank;
  assign bus.wr_idx    = wr_idx;
  assign bus.wr_tag    = wr_tag;
  assign bus.wr_value  = wr_value;
  assign bus.wr_conf   = wr_conf;
  assign bus.wr_useful = wr_useful;
  assign bus.wr_u_only = wr_u_only;
  assign bus.u_rd_en   = u_rd_en;
  assign bus.u_rd_idx  = u_rd_idx;
  assign bus.u_clear   = u_clear;
endmodule

// File: doc/vtage_update_unit.md
Name: vtage_update_unit

Overview:
- Commit-side training engine for the VTAGE value predictor: the write/update counterpart to the bank read path.
- Accepts validated commit records carrying prediction metadata, buffers them, and sequences single-port writes into the base table and the tagged banks.
- Write kinds: confidence/value update, allocation on mispredict, useful-bit clearing.
- Sits between the commit/validation logic and the vtage bank write ports.

Parameters:
P_NUM_BANKS, 6, number of tagged banks; bank id 0 = base table, 1..P_NUM_BANKS = tagged banks
P_VAL_W, 64, predicted value width
P_IDX_W, 10, per-table entry index width
P_TAG_W, 12, tag width
P_CONF_W, 3, confidence counter width; saturates at 2^P_CONF_W-1
P_FIFO_DEPTH, 4, commit buffer depth (power of two)
P_URST_W, 8, useful-reset period is 2^P_URST_W completed updates
(derived) BID_W = $clog2(P_NUM_BANKS+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmt_valid  in  1  commit record valid
cmt_ready  out  1  record accepted when valid&ready
cmt_value  in  P_VAL_W  actual architectural result
cmt_alt_value  in  P_VAL_W  alternate (next-longest) prediction
cmt_prov  in  BID_W  provider bank id
cmt_prov_conf  in  P_CONF_W  provider confidence at predict time
cmt_prov_useful  in  1  provider useful bit at predict time
cmt_pred_value  in  P_VAL_W  provider predicted value
cmt_idx  in  (P_NUM_BANKS+1)*P_IDX_W  per-table index, slot k = bank id k
cmt_tag  in  P_NUM_BANKS*P_TAG_W  per-tagged-bank tag, slot k-1 = bank k
u_rd_en  out  1  request useful bits of all tagged banks
u_rd_idx  out  P_NUM_BANKS*P_IDX_W  indices for u read
u_rd_bits  in  P_NUM_BANKS  useful bits, valid the cycle after u_rd_en; bit k-1 = bank k
wr_en  out  1  bank write strobe
wr_bank  out  BID_W  target bank id
wr_idx  out  P_IDX_W  target entry
wr_tag  out  P_TAG_W  tag to write (0 for base)
wr_value  out  P_VAL_W  value to write
wr_conf  out  P_CONF_W  confidence to write
wr_useful  out  1  useful bit to write
wr_u_only  out  1  when 1 only the useful bit is written
u_clear  out  1  one-cycle global useful-bit clear pulse
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n low at clk edge):
  - FIFO empty; state IDLE; update counter 0.
  - All outputs 0 except cmt_ready=1.
  - Reset mid-operation discards the in-flight record and all buffered records; no partial write follows.
- FIFO: cmt_ready = !full. Push on cmt_valid&cmt_ready. Pop when the head record completes (DONE). Push and pop in the same cycle are both honoured. Records are processed in order.
- Correct = (cmt_pred_value == cmt_value).
- FSM states: IDLE, PROV, URD, CHK, ALLOC, CLR, DONE.
- IDLE: if FIFO non-empty -> PROV.
- PROV: wr_en=1, wr_bank=prov, wr_idx=idx[prov], wr_tag=tag[prov] (0 if prov=0).
  - Correct: wr_conf = min(conf+1, max); wr_value = pred_value; wr_useful = useful | (alt_value != value); -> DONE.
  - Incorrect: wr_conf=0; wr_value=value; wr_useful=useful.
    - If prov==P_NUM_BANKS -> DONE, else -> URD.
  - wr_useful is ignored by the bank for bank id 0.
- URD: u_rd_en=1, u_rd_idx = idx slots 1..P_NUM_BANKS -> CHK.
- CHK: sample u_rd_bits; select lowest bank k > prov with bit==0.
  - Found -> ALLOC, else -> CLR with pointer = prov+1.
- ALLOC: wr_en=1, wr_bank=k, idx[k], tag[k], wr_value=value, wr_conf=0, wr_useful=0 -> DONE.
- CLR: wr_en=1, wr_u_only=1, wr_useful=0, wr_bank=pointer, wr_idx=idx[pointer].
  - Pointer increments each cycle; after pointer==P_NUM_BANKS -> DONE.
- DONE: pop FIFO; update counter +1 (wraps); on wrap to 0, u_clear=1 in the same cycle -> IDLE.
- Exactly one write per cycle maximum. wr_en never asserted in IDLE, URD, CHK or DONE.
- Latency: correct record pushed at cycle t into an empty idle unit writes at t+2. Throughput is 1 record per 3 cycles for the correct path.

Test Plan:
- Correct prediction: prov=2, conf=3, useful=0, alt≠value -> one write at t+2: bank 2, conf=4, useful=1; no u_rd_en.
- Saturation: prov=1, conf=7, correct -> wr_conf=7.
- Mispredict with free bank: prov=1, u_rd_bits=6'b111010 -> PROV write conf=0, value=actual; URD; ALLOC into bank 3 with tag[3], conf 0, useful 0.
- Mispredict with no free bank: prov=4, u_rd_bits all 1 -> u-only clears to banks 5 and 6 on consecutive cycles, then DONE.
- Backpressure: push 5 records back-to-back with P_FIFO_DEPTH=4 -> cmt_ready low after 4 accepted; 5th accepted after the first DONE; in-order write sequence.
- Useful reset and reset mid-op: 256 completed updates -> exactly one u_clear pulse. rst_n low during CLR -> next cycle wr_en=0, busy=0, cmt_ready=1.
